// File: rtl/multiplier_pkg.sv
// Shared types for the shift-and-add multiplier.
package multiplier_pkg;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    CALC = 2'd1,
    DONE = 2'd2
  } mult_state_e;

endpackage : multiplier_pkg

// File: rtl/adder_nnbit_serial.sv
// Purely combinational ripple-carry adder used by the shift-and-add multiplier.
module adder_nnbit_serial #(
  parameter int unsigned DATA_WIDTH = 8
) (
  input  logic [DATA_WIDTH-1:0] i_a,
  input  logic [DATA_WIDTH-1:0] i_b,
  input  logic                  i_cry,
  output logic [DATA_WIDTH-1:0] o_sum,
  output logic                  o_cry
);

  // Bit-serial carry chain, one full adder per bit.
  always_comb begin : ripple
    logic carry;
    o_sum = '0;
    carry = i_cry;
    for (int i = 0; i < int'(DATA_WIDTH); i++) begin
      o_sum[i] = i_a[i] ^ i_b[i] ^ carry;
      carry    = (i_a[i] & i_b[i]) | (carry & (i_a[i] ^ i_b[i]));
    end
    o_cry = carry;
  end

endmodule : adder_nnbit_serial

// File: rtl/multiplier_nnbit_shift.sv
// Sequential unsigned shift-and-add multiplier, one partial-product step per clock.
// Optional MULTIPLIER_NNBIT_SHIFT_ZERO_BYPASS_EN: zero operands skip CALC and finish in one edge.
module multiplier_nnbit_shift
  import multiplier_pkg::*;
#(
  parameter int unsigned DATA_WIDTH = 8
) (
  input  logic                    i_clk,
  input  logic                    i_rst,
  input  logic                    i_vld,
  output logic                    o_rdy,
  input  logic [DATA_WIDTH-1:0]   i_num_a,
  input  logic [DATA_WIDTH-1:0]   i_num_b,
  output logic                    o_vld,
  input  logic                    i_rdy,
  output logic [2*DATA_WIDTH-1:0] o_res,
  output logic                    o_busy
);

  localparam int unsigned CNT_W  = $clog2(DATA_WIDTH);
  localparam int unsigned PROD_W = 2 * DATA_WIDTH;

  mult_state_e             state_q, state_d;
  logic [CNT_W-1:0]        cnt_q, cnt_d;
  logic [DATA_WIDTH-1:0]   a_q, a_d;
  logic [DATA_WIDTH-1:0]   b_q, b_d;
  logic [PROD_W-1:0]       prod_q, prod_d;
  logic                    rdy_q, rdy_d;
  logic                    vld_q, vld_d;
  logic                    busy_q, busy_d;
  logic [PROD_W-1:0]       res_q, res_d;

  logic [DATA_WIDTH-1:0]   addend_c;
  logic [DATA_WIDTH-1:0]   sum_c;
  logic                    cry_c;

  assign addend_c = b_q[0] ? a_q : '0;

  adder_nnbit_serial #(
    .DATA_WIDTH (DATA_WIDTH)
  ) u_adder (
    .i_a   (prod_q[PROD_W-1:DATA_WIDTH]),
    .i_b   (addend_c),
    .i_cry (1'b0),
    .o_sum (sum_c),
    .o_cry (cry_c)
  );

  // Next-state, datapath and registered-output decode.
  always_comb begin
    state_d = state_q;
    cnt_d   = cnt_q;
    a_d     = a_q;
    b_d     = b_q;
    prod_d  = prod_q;

    case (state_q)
      IDLE: begin
        if (i_vld) begin
          a_d     = i_num_a;
          b_d     = i_num_b;
          prod_d  = '0;
          cnt_d   = CNT_W'(DATA_WIDTH - 1);
          state_d = CALC;
`ifdef MULTIPLIER_NNBIT_SHIFT_ZERO_BYPASS_EN
          if ((i_num_a == '0) || (i_num_b == '0)) begin
            cnt_d   = '0;
            state_d = DONE;
          end
`endif
        end
      end
      CALC: begin
        // Carry-out becomes the new MSB as the whole product shifts right.
        prod_d = {cry_c, sum_c, prod_q[DATA_WIDTH-1:1]};
        b_d    = b_q >> 1;
        cnt_d  = CNT_W'(cnt_q - 1'b1);
        if (cnt_q == '0) begin
          state_d = DONE;
        end
      end
      DONE: begin
        if (i_rdy) begin
          state_d = IDLE;
        end
      end
      default: state_d = IDLE;
    endcase

    rdy_d  = (state_d == IDLE);
    vld_d  = (state_d == DONE);
    busy_d = (state_d == CALC);
    res_d  = vld_d ? prod_d : '0;
  end

  always_ff @(posedge i_clk) begin
    if (i_rst) begin
      state_q <= IDLE;
      cnt_q   <= '0;
      a_q     <= '0;
      b_q     <= '0;
      prod_q  <= '0;
      rdy_q   <= 1'b1;
      vld_q   <= 1'b0;
      busy_q  <= 1'b0;
      res_q   <= '0;
    end else begin
      state_q <= state_d;
      cnt_q   <= cnt_d;
      a_q     <= a_d;
      b_q     <= b_d;
      prod_q  <= prod_d;
      rdy_q   <= rdy_d;
      vld_q   <= vld_d;
      busy_q  <= busy_d;
      res_q   <= res_d;
    end
  end

  assign o_rdy  = rdy_q;
  assign o_vld  = vld_q;
  assign o_busy = busy_q;
  assign o_res  = res_q;

endmodule : multiplier_nnbit_shift

// File: tb/tb_multiplier_nnbit_shift.sv
// Directed self-checking bench for multiplier_nnbit_shift (DATA_WIDTH = 8).
module tb_multiplier_nnbit_shift;

  localparam int unsigned W = 8;

  logic           i_clk;
  logic           i_rst;
  logic           i_vld;
  logic           o_rdy;
  logic [W-1:0]   i_num_a;
  logic [W-1:0]   i_num_b;
  logic           o_vld;
  logic           i_rdy;
  logic [2*W-1:0] o_res;
  logic           o_busy;

  int n_chk  = 0;
  int n_fail = 0;

  multiplier_nnbit_shift #(.DATA_WIDTH(W)) dut (
    .i_clk   (i_clk),
    .i_rst   (i_rst),
    .i_vld   (i_vld),
    .o_rdy   (o_rdy),
    .i_num_a (i_num_a),
    .i_num_b (i_num_b),
    .o_vld   (o_vld),
    .i_rdy   (i_rdy),
    .o_res   (o_res),
    .o_busy  (o_busy)
  );

  initial i_clk = 1'b0;
  always #5 i_clk = ~i_clk;

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_chk++;
    assert (obs === exp) else begin
      n_fail++;
      $error("FAIL %s observed=%0d expected=%0d", tag, obs, exp);
    end
  endtask

  // Called at a negedge while idle; returns at the negedge where o_vld is seen (or bound expires).
  task automatic run_op(input logic [W-1:0] a, input logic [W-1:0] b,
                        output int lat, output int busy);
    i_vld   = 1'b1;
    i_num_a = a;
    i_num_b = b;
    @(negedge i_clk);
    i_vld = 1'b0;
    lat   = 0;
    busy  = 0;
    while (!o_vld && lat < 40) begin
      if (o_busy) busy++;
      @(negedge i_clk);
      lat++;
    end
  endtask

  int lat, busy, vld_seen;
  int exp_zero_lat, exp_zero_busy;

  initial begin
`ifdef MULTIPLIER_NNBIT_SHIFT_ZERO_BYPASS_EN
    exp_zero_lat  = 0;
    exp_zero_busy = 0;
`else
    exp_zero_lat  = 8;
    exp_zero_busy = 8;
`endif
    i_rst = 1'b1; i_vld = 1'b0; i_rdy = 1'b1; i_num_a = '0; i_num_b = '0;
    repeat (2) @(negedge i_clk);
    check("rst_rdy",  32'(o_rdy),  32'd1);
    check("rst_vld",  32'(o_vld),  32'd0);
    check("rst_busy", 32'(o_busy), 32'd0);
    check("rst_res",  32'(o_res),  32'd0);
    i_rst = 1'b0;
    @(negedge i_clk);

    // 13 * 11 with downstream always ready
    run_op(8'd13, 8'd11, lat, busy);
    check("13x11_lat",  32'(lat),   32'd8);
    check("13x11_busy", 32'(busy),  32'd8);
    check("13x11_res",  32'(o_res), 32'd143);
    check("13x11_rdy_in_done", 32'(o_rdy), 32'd0);
    @(negedge i_clk);
    check("13x11_vld_fall", 32'(o_vld), 32'd0);
    check("13x11_rdy_rise", 32'(o_rdy), 32'd1);
    check("idle_res_zero",  32'(o_res), 32'd0);

    // 255 * 255 exercises adder carry-out, held in DONE with i_rdy low
    i_rdy = 1'b0;
    run_op(8'd255, 8'd255, lat, busy);
    check("ffxff_lat", 32'(lat),   32'd8);
    check("ffxff_res", 32'(o_res), 32'hFE01);
    for (int k = 0; k < 5; k++) begin
      @(negedge i_clk);
      check("hold_vld", 32'(o_vld), 32'd1);
      check("hold_res", 32'(o_res), 32'hFE01);
      check("hold_rdy", 32'(o_rdy), 32'd0);
    end
    i_rdy = 1'b1;
    @(negedge i_clk);
    check("release_vld", 32'(o_vld), 32'd0);
    check("release_rdy", 32'(o_rdy), 32'd1);

    // i_vld pulsed with 7,9 mid-CALC must be ignored
    i_vld = 1'b1; i_num_a = 8'd13; i_num_b = 8'd11;
    @(negedge i_clk);
    i_vld = 1'b0;
    @(negedge i_clk);
    i_vld = 1'b1; i_num_a = 8'd7; i_num_b = 8'd9;
    @(negedge i_clk);
    i_vld = 1'b0; i_num_a = '0; i_num_b = '0;
    lat = 2;
    while (!o_vld && lat < 40) begin
      @(negedge i_clk);
      lat++;
    end
    check("ignore_lat", 32'(lat),   32'd8);
    check("ignore_res", 32'(o_res), 32'd143);
    @(negedge i_clk);
    run_op(8'd7, 8'd9, lat, busy);
    check("7x9_res", 32'(o_res), 32'd63);
    check("7x9_lat", 32'(lat),   32'd8);
    @(negedge i_clk);

    // Reset at CALC step 4 aborts without a result
    i_vld = 1'b1; i_num_a = 8'd13; i_num_b = 8'd11;
    @(negedge i_clk);
    i_vld = 1'b0;
    repeat (3) @(negedge i_clk);
    check("pre_abort_busy", 32'(o_busy), 32'd1);
    i_rst = 1'b1;
    @(negedge i_clk);
    i_rst = 1'b0;
    check("abort_rdy",  32'(o_rdy),  32'd1);
    check("abort_busy", 32'(o_busy), 32'd0);
    check("abort_res",  32'(o_res),  32'd0);
    vld_seen = 0;
    for (int k = 0; k < 12; k++) begin
      if (o_vld) vld_seen++;
      @(negedge i_clk);
    end
    check("abort_no_vld", 32'(vld_seen), 32'd0);
    run_op(8'd3, 8'd5, lat, busy);
    check("3x5_res", 32'(o_res), 32'd15);
    check("3x5_lat", 32'(lat),   32'd8);
    @(negedge i_clk);

    // Zero operand: bypass or full path depending on build
    run_op(8'd0, 8'd200, lat, busy);
    check("zero_lat",  32'(lat),   32'(exp_zero_lat));
    check("zero_busy", 32'(busy),  32'(exp_zero_busy));
    check("zero_vld",  32'(o_vld), 32'd1);
    check("zero_res",  32'(o_res), 32'd0);
    @(negedge i_clk);
    check("zero_back_idle", 32'(o_rdy), 32'd1);

    $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
    $finish;
  end

endmodule : tb_multiplier_nnbit_shift
